// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle multiply / multiply-accumulate / restoring-divide engine.
// HI/LO are read through a plain mux; busy/op_ready let the pipeline stall while an op is in flight.
module hilo_muldiv #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              read_hi,
  output logic [DATA_W-1:0] hilo_data_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + MUL_LAT + 1);

  localparam logic [3:0] OP_MTHI  = 4'd0;
  localparam logic [3:0] OP_MTLO  = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_DIVU  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic [3:0]          op_q, op_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

  logic                accept, is_mul_op, is_div_op, div_signed, mul_signed;
  logic [DATA_W-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic [2*DATA_W-1:0] ext_a, ext_b, product, mul_res;

  assign op_ready      = (state_q == S_IDLE);
  assign busy          = ~op_ready;
  assign done          = done_q;
  assign hilo_data_out = read_hi ? hi_q : lo_q;

  assign accept     = op_valid & op_ready & ~flush;
  assign is_mul_op  = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_MADD) | (op == OP_MADDU) |
                      (op == OP_MSUB) | (op == OP_MSUBU);
  assign is_div_op  = (op == OP_DIV) | (op == OP_DIVU);
  assign div_signed = (op == OP_DIV);
  assign mag_a      = (div_signed & src_a[DATA_W-1]) ? -src_a : src_a;
  assign mag_b      = (div_signed & src_b[DATA_W-1]) ? -src_b : src_b;

  // Multiply on latched operands; sign-extending to 2*DATA_W makes one unsigned multiplier serve both.
  assign mul_signed = (op_q == OP_MULT) | (op_q == OP_MADD) | (op_q == OP_MSUB);
  assign ext_a      = mul_signed ? {{DATA_W{opa_q[DATA_W-1]}}, opa_q} : {{DATA_W{1'b0}}, opa_q};
  assign ext_b      = mul_signed ? {{DATA_W{opb_q[DATA_W-1]}}, opb_q} : {{DATA_W{1'b0}}, opb_q};
  assign product    = ext_a * ext_b;

  always_comb begin
    mul_res = product;
    if ((op_q == OP_MADD) | (op_q == OP_MADDU)) mul_res = {hi_q, lo_q} + product;
    if ((op_q == OP_MSUB) | (op_q == OP_MSUBU)) mul_res = {hi_q, lo_q} - product;
  end

  // Restoring step: opa_q shifts the dividend out at the top and the quotient in at the bottom.
  assign rem_sh   = {rem_q, opa_q[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign quo_fix  = qneg_q ? -opa_q : opa_q;
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op;
          if (is_mul_op) begin
            state_d = S_MUL;
            opa_d   = src_a;
            opb_d   = src_b;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else if (is_div_op) begin
            if (src_b == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_DIV;
              opa_d   = mag_a;
              opb_d   = mag_b;
              rem_d   = '0;
              cnt_d   = '0;
              qneg_d  = div_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
              rneg_d  = div_signed & src_a[DATA_W-1];
            end
          end else begin
            done_d = 1'b1;
            if (op == OP_MTHI) hi_d = src_a;
            if (op == OP_MTLO) lo_d = src_a;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          hi_d    = rem_fix;
          lo_d    = quo_fix;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
          opa_d = {opa_q[DATA_W-2:0], ~rem_diff[DATA_W]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random ops against an arithmetic model.
module tb_hilo_muldiv;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clock = 1'b0;
  logic         reset, op_valid, flush, read_hi;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, hilo_data_out;
  logic         op_ready, busy, done;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi, m_lo;

  hilo_muldiv #(.DATA_W(W), .MUL_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .read_hi(read_hi),
    .hilo_data_out(hilo_data_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    read_hi = 1'b1;
    #1 hi = hilo_data_out;
    read_hi = 1'b0;
    #1 lo = hilo_data_out;
  endtask

  task automatic check_hilo(input string tag);
    logic [W-1:0] hi, lo;
    read_hilo(hi, lo);
    check(tag, {hi, lo}, {m_hi, m_lo});
  endtask

  // Reference: arithmetic straight from the op definitions; returns write latency in edges.
  function automatic int model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] acc, p;
    int          sa, sb;
    acc = {m_hi, m_lo};
    sa  = a;
    sb  = b;
    case (o)
      4'd0: begin m_hi = a; return 0; end
      4'd1: begin m_lo = a; return 0; end
      4'd2, 4'd6, 4'd8: p = longint'(sa) * longint'(sb);
      4'd3, 4'd7, 4'd9: p = {32'b0, a} * {32'b0, b};
      4'd4: begin
        if (b == 0) return 0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 0;
        end else begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
        return W + 1;
      end
      4'd5: begin
        if (b == 0) return 0;
        m_lo = a / b;
        m_hi = a % b;
        return W + 1;
      end
      default: return 0;
    endcase
    if (o == 4'd6 || o == 4'd7) p = acc + p;
    if (o == 4'd8 || o == 4'd9) p = acc - p;
    {m_hi, m_lo} = p;
    return LAT;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit poke);
    int           lat, k;
    logic [W-1:0] pre_hi, pre_lo, hi, lo;
    k = 0;
    while (!op_ready && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    check({tag, " ready"}, op_ready, 1'b1);
    pre_hi   = m_hi;
    pre_lo   = m_lo;
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(posedge clock); #1;
    op_valid = 1'b0;
    op       = 4'($urandom_range(0, 15));
    src_a    = $urandom;
    src_b    = $urandom;
    lat      = model(o, a, b);
    k        = 0;
    while (!done && k < 60) begin
      check({tag, " busy"}, busy, 1'b1);
      read_hilo(hi, lo);
      check({tag, " pre-op read"}, {hi, lo}, {pre_hi, pre_lo});
      if (poke && k == 5) begin
        op_valid = 1'b1;
        op       = 4'd0;
        src_a    = 32'hDEAD_BEEF;
      end else begin
        op_valid = 1'b0;
      end
      @(posedge clock); #1;
      k++;
    end
    op_valid = 1'b0;
    check({tag, " latency"}, k, lat);
    check({tag, " ready at done"}, {op_ready, busy}, 2'b10);
    check_hilo({tag, " result"});
    @(posedge clock); #1;
    check({tag, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    logic [3:0]   o;
    logic [W-1:0] a, b, hi, lo;
    bit           seen_done;

    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; read_hi = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset state", {op_ready, busy, done}, 3'b100);
    check_hilo("reset hilo");

    // Asynchronous reset mid-cycle while a multiply is in flight.
    run_op(4'd0, 32'h1111_1111, 0, "preload hi", 1'b0);
    run_op(4'd1, 32'h2222_2222, 0, "preload lo", 1'b0);
    op_valid = 1'b1; op = 4'd2; src_a = 3; src_b = 5;
    @(posedge clock); #1;
    op_valid = 1'b0;
    check("busy before reset", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check_hilo("async reset hilo");
    check("async reset flags", {op_ready, busy, done}, 3'b100);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    check("no done after reset", done, 1'b0);
    check_hilo("hilo after reset");

    run_op(4'd0, 32'h1234_5678, 0, "MTHI", 1'b0);
    run_op(4'd1, 32'hA5A5_A5A5, 0, "MTLO", 1'b0);
    run_op(4'd2, 32'hFFFF_FFFF, 2, "MULT", 1'b0);
    run_op(4'd3, 32'hFFFF_FFFF, 2, "MULTU", 1'b0);
    run_op(4'd4, -32'sd7, 2, "DIV -7/2", 1'b1);
    run_op(4'd5, 7, 0, "DIVU by zero", 1'b0);
    run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow", 1'b0);
    run_op(4'd4, 7, 0, "DIV by zero", 1'b0);
    run_op(4'd0, 0, 0, "MTHI 0", 1'b0);
    run_op(4'd1, 5, 0, "MTLO 5", 1'b0);
    run_op(4'd6, 3, 4, "MADD", 1'b0);
    run_op(4'd1, 0, 0, "MTLO 0", 1'b0);
    run_op(4'd9, 1, 1, "MSUBU", 1'b0);
    run_op(4'd12, 32'h5555_5555, 1, "NOP", 1'b0);

    // Flush during a divide: no write, no done, idle again next cycle.
    op_valid = 1'b1; op = 4'd4; src_a = 100; src_b = 7;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("div flush flags", {op_ready, busy, done}, 3'b100);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen_done = 1'b1;
    end
    check("div flush no done", seen_done, 1'b0);
    check_hilo("div flush hilo");

    // Flush on the final multiply cycle suppresses the write.
    op_valid = 1'b1; op = 4'd3; src_a = 32'hDEAD_0001; src_b = 32'h0000_0777;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (LAT - 1) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("mul flush flags", {op_ready, busy, done}, 3'b100);
    check_hilo("mul flush hilo");

    // Flush coinciding with a would-be accept drops the op.
    op_valid = 1'b1; flush = 1'b1; op = 4'd0; src_a = 32'h0BAD_0BAD;
    @(posedge clock); #1;
    op_valid = 1'b0; flush = 1'b0;
    check("flush accept flags", {op_ready, busy, done}, 3'b100);
    check_hilo("flush accept hilo");

    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if (o == 4'd4 && $urandom_range(0, 7) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(o, a, b, $sformatf("rand%0d op%0d", i, o), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end
endmodule
